stream_mux_rr: RTL

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

---
 rtl/stream_mux_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/stream_mux_rr.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants for the stream mux: default geometry and the arbitration mode encoding.
package stream_mux_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_NCH   = 4;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request scanner: first set request at ptr, ptr+1, ... wrapping modulo NCH.
// Latency: purely combinational.
// Backpressure: none; grant is a pure function of requests and pointer.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int NCH = DEFAULT_NCH,
  parameter int SW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [SW-1:0]  ptr_i,
  output logic [NCH-1:0] gnt_o,
  output logic [SW-1:0]  gnt_idx_o,
  output logic           gnt_vld_o
);

  logic [SW-1:0] cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    cand      = '0;
    for (int i = 0; i < NCH; i++) begin
      cand = SW'((int'(ptr_i) + i) % NCH);
      if (!gnt_vld_o && req_i[cand]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = cand;
      end
    end
    gnt_o[gnt_idx_o] = gnt_vld_o;
  end

endmodule

// File: rtl/stream_mux_rr.sv
// NCH:1 stream mux, fixed-select or round-robin; STREAM_MUX_PKT_LOCK_EN adds packet locking.
// Latency: 1 cycle from input handshake to registered output.
// Backpressure: input ready only while the output register is empty or draining this cycle.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NCH   = DEFAULT_NCH,
  localparam int SW   = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SW-1:0]        sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [NCH-1:0]       in_last,
  output logic                 out_last,
`endif
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SW-1:0]        out_ch
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SW-1:0]    out_ch_q, out_ch_d;
  logic [SW-1:0]    ptr_q, ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic             lock_q, lock_d;
  logic [SW-1:0]    lock_ch_q, lock_ch_d;
  logic             out_last_q, out_last_d;
`endif

  logic [NCH-1:0]   arb_gnt;
  logic [SW-1:0]    arb_idx;
  logic             arb_vld;
  logic             fix_vld;
  logic             gnt_vld;
  logic [SW-1:0]    gnt_idx;
  logic             free;
  logic             xfer;
  logic [WIDTH-1:0] sel_dat;

  rr_arbiter #(.NCH(NCH), .SW(SW)) u_arb (
    .req_i     (in_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .gnt_vld_o (arb_vld)
  );

  always_comb begin
    // Out-of-range sel (non power-of-two NCH) matches no channel and so grants nothing.
    fix_vld = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SW'(k)) fix_vld = in_valid[k];
    end

    gnt_vld = 1'b0;
    gnt_idx = '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (lock_q) begin
      gnt_vld = in_valid[lock_ch_q];
      gnt_idx = lock_ch_q;
    end else
`endif
    if (mode == MODE_FIXED) begin
      gnt_vld = fix_vld;
      gnt_idx = sel;
    end else begin
      gnt_vld = arb_vld && (arb_gnt != '0);
      gnt_idx = arb_idx;
    end

    free = !out_valid_q || out_ready;
    xfer = rst_n && free && gnt_vld;

    in_ready = '0;
    sel_dat  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt_idx == SW'(k)) begin
        in_ready[k] = xfer;
        sel_dat     = in_data[k*WIDTH +: WIDTH];
      end
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    out_last_d  = out_last_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_dat;
      out_ch_d    = gnt_idx;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_d      = !in_last[gnt_idx];
      lock_ch_d   = gnt_idx;
      out_last_d  = in_last[gnt_idx];
`endif
      if (mode == MODE_RR) begin
        ptr_d = (gnt_idx == SW'(NCH - 1)) ? '0 : gnt_idx + SW'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule
